// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: instruction memory,
// decode and the PC-select mux.
interface fetch_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc_plus1;

  // The fetch stage is the master; memory, decode and the mux form the slave side.
  modport master (
    input  next_pc, redirect, mem_rd_ack, mem_rd_data, instr_ready,
    output mem_rd_req, mem_addr, instr, instr_pc, instr_valid, pc_plus1
  );

  modport slave (
    output next_pc, redirect, mem_rd_ack, mem_rd_data, instr_ready,
    input  mem_rd_req, mem_addr, instr, instr_pc, instr_valid, pc_plus1
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads one byte per request from
// instruction memory and hands it to decode, honouring branch redirects.
module fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_HOLD
  } state_e;

  state_e            state,      state_nxt;
  logic [ADDR_W-1:0] pc,         pc_nxt;
  logic [ADDR_W-1:0] redir_pc,   redir_pc_nxt;
  logic              redir_pend, redir_pend_nxt;
  logic [DATA_W-1:0] instr_q,    instr_nxt;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      redir_pc   <= RESET_PC;
      redir_pend <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state      <= state_nxt;
      pc         <= pc_nxt;
      redir_pc   <= redir_pc_nxt;
      redir_pend <= redir_pend_nxt;
      instr_q    <= instr_nxt;
      instr_pc_q <= instr_pc_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    pc_nxt         = pc;
    redir_pc_nxt   = redir_pc;
    redir_pend_nxt = redir_pend;
    instr_nxt      = instr_q;
    instr_pc_nxt   = instr_pc_q;

    case (state)
      S_IDLE: state_nxt = S_REQ;

      S_REQ: begin
        if (bus.mem_rd_ack) begin
          if (redir_pend || bus.redirect) begin
            // A redirect landed during the read: drop the byte, jump to the
            // newest target (this cycle's redirect beats the stored one).
            pc_nxt         = bus.redirect ? bus.next_pc : redir_pc;
            redir_pend_nxt = 1'b0;
            state_nxt      = S_GAP;
          end else begin
            instr_nxt    = bus.mem_rd_data;
            instr_pc_nxt = pc;
            state_nxt    = S_HOLD;
          end
        end else if (bus.redirect) begin
          // The read cannot be cancelled, so remember the target until it acks.
          redir_pend_nxt = 1'b1;
          redir_pc_nxt   = bus.next_pc;
        end
      end

      S_GAP: begin
        if (bus.redirect) pc_nxt = bus.next_pc;
        state_nxt = S_REQ;
      end

      S_HOLD: begin
        if (bus.redirect || bus.instr_ready) begin
          pc_nxt    = bus.next_pc;
          state_nxt = S_GAP;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_rd_req  = (state == S_REQ);
    bus.instr_valid = (state == S_HOLD);
    bus.mem_addr    = pc;
    bus.pc_plus1    = pc + ADDR_W'(1);
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random memory latency,
// decode back-pressure and redirects, all checked against a transaction model.
module tb_fetch_stage;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(8'h00)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: which phase of a fetch the stage should be in, where it
  // should be reading, and the instruction it should be offering to decode.
  bit         m_startup, m_reading, m_gap, m_holding;
  logic [7:0] m_pc, m_instr, m_instr_pc;
  logic [7:0] redir_q[$];
  logic [7:0] mem[256];
  logic [7:0] obs_instr[$];
  logic [7:0] obs_pc[$];
  int         valid_cnt = 0;

  task automatic model_reset();
    m_startup  = 1'b1;
    m_reading  = 1'b0;
    m_gap      = 1'b0;
    m_holding  = 1'b0;
    m_pc       = 8'h00;
    m_instr    = 8'h00;
    m_instr_pc = 8'h00;
    redir_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},      bus.mem_rd_req,  1'b0);
    check({tag, "_valid"},    bus.instr_valid, 1'b0);
    check({tag, "_instr"},    bus.instr,       8'h00);
    check({tag, "_instr_pc"}, bus.instr_pc,    8'h00);
    check({tag, "_addr"},     bus.mem_addr,    8'h00);
    check({tag, "_pc_plus1"}, bus.pc_plus1,    8'h01);
  endtask

  // One clock cycle, entered just after a falling edge: check outputs, drive
  // inputs, advance the model to what the next rising edge should produce.
  task automatic step(input bit ack, input logic [7:0] data, input bit redir,
                      input logic [7:0] tgt, input bit ready);
    logic [7:0] inc;
    logic [7:0] nxt;
    inc = m_pc + 8'd1;
    check("req",      bus.mem_rd_req,  m_reading);
    check("addr",     bus.mem_addr,    m_pc);
    check("pc_plus1", bus.pc_plus1,    inc);
    check("valid",    bus.instr_valid, m_holding);
    if (m_holding) begin
      check("instr",    bus.instr,    m_instr);
      check("instr_pc", bus.instr_pc, m_instr_pc);
    end
    if (bus.instr_valid === 1'b1) valid_cnt++;
    if (bus.instr_valid === 1'b1 && ready) begin
      obs_instr.push_back(bus.instr);
      obs_pc.push_back(bus.instr_pc);
    end

    nxt = redir ? tgt : inc;
    bus.mem_rd_ack  = ack;
    bus.mem_rd_data = data;
    bus.redirect    = redir;
    bus.next_pc     = nxt;
    bus.instr_ready = ready;

    if (m_startup) begin
      m_startup = 1'b0;
      m_reading = 1'b1;
    end else if (m_reading) begin
      if (ack) begin
        if (redir || redir_q.size() != 0) begin
          m_pc = redir ? tgt : redir_q[$];
          redir_q.delete();
          m_reading = 1'b0;
          m_gap     = 1'b1;
        end else begin
          m_instr    = data;
          m_instr_pc = m_pc;
          m_reading  = 1'b0;
          m_holding  = 1'b1;
        end
      end else if (redir) begin
        redir_q.push_back(tgt);
      end
    end else if (m_gap) begin
      if (redir) m_pc = tgt;
      m_gap     = 1'b0;
      m_reading = 1'b1;
    end else if (m_holding) begin
      if (redir || ready) begin
        m_pc      = nxt;
        m_holding = 1'b0;
        m_gap     = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int v0;
    bus.mem_rd_ack  = 1'b0;
    bus.mem_rd_data = '0;
    bus.redirect    = 1'b0;
    bus.next_pc     = '0;
    bus.instr_ready = 1'b0;
    model_reset();

    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Sequential fetch with same-cycle ack and data = addr ^ A5.
    for (int i = 0; i < 9; i++) step(m_reading, m_pc ^ 8'hA5, 1'b0, 8'h00, 1'b1);
    check("t1_valid_cnt", valid_cnt, 3);
    check("t1_count", obs_instr.size(), 3);
    if (obs_instr.size() >= 3) begin
      check("t1_instr0", obs_instr[0], 8'hA5);
      check("t1_instr1", obs_instr[1], 8'hA4);
      check("t1_instr2", obs_instr[2], 8'hA7);
      check("t1_pc0",    obs_pc[0],    8'h00);
      check("t1_pc1",    obs_pc[1],    8'h01);
      check("t1_pc2",    obs_pc[2],    8'h02);
    end

    // Decode stalls five cycles; stray acks outside REQ must be ignored.
    for (int i = 0; i < 8 && !m_holding; i++) step(m_reading, m_pc ^ 8'hA5, 1'b0, 8'h00, 1'b1);
    check("t2_in_hold", m_holding, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0);
    check("t2_instr_held", bus.instr, 8'hA6);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Redirect at pc 04 while the read is outstanding; ack three cycles later.
    check("t3_start", bus.mem_addr, 8'h04);
    v0 = valid_cnt;
    step(1'b0, 8'h00, 1'b1, 8'h40, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    check("t3_gap_req", bus.mem_rd_req, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("t3_addr", bus.mem_addr, 8'h40);
    check("t3_req", bus.mem_rd_req, 1'b1);
    check("t3_dropped", valid_cnt - v0, 0);

    // Two redirects while one read is pending: the last target wins.
    step(1'b0, 8'h00, 1'b1, 8'h20, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'h30, 1'b1);
    step(1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("t4_addr", bus.mem_addr, 8'h30);

    // Redirect from HOLD to FF, then wrap to 00.
    step(1'b1, 8'h30 ^ 8'hA5, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("t5_addr_ff", bus.mem_addr, 8'hFF);
    check("t5_pc_plus1", bus.pc_plus1, 8'h00);
    step(1'b1, 8'hFF ^ 8'hA5, 1'b0, 8'h00, 1'b0);
    check("t5_instr", bus.instr, 8'h5A);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("t5_wrap", bus.mem_addr, 8'h00);
    check("t5_req", bus.mem_rd_req, 1'b1);

    // Asynchronous reset in the middle of REQ, with an ack arriving during it.
    bus.instr_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("t6");
    bus.mem_rd_ack  = 1'b1;
    bus.mem_rd_data = 8'h33;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("t6_hold");
    reset_n = 1'b1;
    model_reset();
    step(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    check("t6_addr", bus.mem_addr, 8'h00);
    check("t6_req", bus.mem_rd_req, 1'b1);

    // Random traffic over random memory contents.
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      bit         ack;
      bit         redir;
      logic [7:0] data;
      ack   = m_reading ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
      data  = m_reading ? mem[m_pc] : 8'($urandom);
      redir = ($urandom_range(0, 6) == 0);
      step(ack, data, redir, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
